f3_button_cond: RTL and testbench
=================================

Name: f3_button_cond

Overview:
- Input conditioning stage for the function-3 direction/scramble buttons; sits directly upstream of the function-3 key processor and drives its East/West/North/South/Scramble inputs.
- Per channel: 2-flop synchroniser, counter-based debouncer, rising-edge one-shot, and auto-repeat on the four directional channels.
- Emits clean single-cycle pulses that the key processor samples on sysclk.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles of a changed synchronised level before the debounced level follows (10 ms at 50 MHz); legal ≥1.
- REPEAT_DELAY, 25000000, cycles from press pulse to first repeat pulse (directional only); 0 disables auto-repeat.
- REPEAT_RATE, 5000000, cycles between subsequent repeat pulses; legal ≥1.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- east_raw  in  1  asynchronous raw East button, active high.
- west_raw  in  1  asynchronous raw West button, active high.
- north_raw  in  1  asynchronous raw North button, active high.
- south_raw  in  1  asynchronous raw South button, active high.
- scramble_raw  in  1  asynchronous raw Scramble button, active high.
- East  out  1  one-cycle pulse: East press or repeat.
- West  out  1  one-cycle pulse: West press or repeat.
- North  out  1  one-cycle pulse: North press or repeat.
- South  out  1  one-cycle pulse: South press or repeat.
- Scramble  out  1  one-cycle pulse: Scramble press only (never repeats).
- held  out  5  debounced levels {scramble,south,north,west,east}.

Behaviour:
- Reset (sampled at a sysclk edge with reset=1): all sync flops, debounced levels, debounce counters, repeat counters, pulse outputs and held clear to 0. Reset overrides all other activity, including mid-debounce and mid-repeat.
- The five channels are fully independent. Simultaneous pulses on several outputs are legal; priority is resolved downstream.
- Synchroniser: s1 <= raw; s2 <= s1.
- Debouncer: per-channel counter, width clog2(DEBOUNCE_CYCLES+1).
  - If s2 == deb: counter <= 0.
  - Otherwise counter increments. On the edge where it would reach DEBOUNCE_CYCLES: deb <= s2 and counter <= 0.
  - Any single cycle of agreement restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles never change deb.
- Press pulse: output <= deb_next & ~deb (registered), high for exactly one cycle.
- Latency: let edge 1 be the first edge sampling raw=1 with raw held. s2=1 after edge 2, deb=1 after edge 2+DEBOUNCE_CYCLES, pulse high after edge 3+DEBOUNCE_CYCLES. Release is debounced identically and produces no pulse.
- Auto-repeat (directional channels, REPEAT_DELAY>0): repeat FSM per channel with states IDLE, DELAY, REPEAT.
  - IDLE: on press pulse, go to DELAY with rcnt=0.
  - DELAY: rcnt increments each cycle. When rcnt reaches REPEAT_DELAY-1, emit a pulse, go to REPEAT, rcnt=0. The first repeat is therefore REPEAT_DELAY cycles after the press pulse.
  - REPEAT: pulse every REPEAT_RATE cycles.
  - deb falling in DELAY or REPEAT returns the FSM to IDLE in the same edge with no pulse.
  - rcnt width: clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
- Held through reset release: treated as a new press; pulse at DEBOUNCE_CYCLES+3 edges after the first post-reset edge.
- held reflects deb directly (no extra register stage).

Test Plan:
- DEBOUNCE_CYCLES=4, REPEAT_DELAY=0; east_raw rises before edge 1 and stays high -> East=1 only in the cycle after edge 7; held[0]=1 after edge 6; no other output toggles.
- DEBOUNCE_CYCLES=4; north_raw high for 3 cycles then low, repeated 5 times -> North never asserts; held[2] stays 0.
- DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8; hold south_raw 60 cycles -> South pulses at the press cycle P, then P+20, P+28, P+36, P+44, P+52 (if still held); after release, no further pulses.
- Same parameters; hold scramble_raw 60 cycles -> exactly one Scramble pulse.
- east_raw and west_raw rise on the same cycle -> East and West pulse on the same cycle.
- Assert reset for 1 cycle mid-DELAY with west_raw held -> all outputs 0 after the reset edge; West re-pulses 7 edges later (DEBOUNCE_CYCLES=4); repeat timing restarts from that pulse.

Source files
------------

// File: rtl/f3_button_cond.sv
// ---------------------------------------------------------------------------
// f3_button_cond
//
// Conditions the five raw function-3 buttons (East, West, North, South,
// Scramble) into clean single-cycle pulses for the function-3 key processor.
// Each channel is fully independent and contains:
//   - a 2-flop synchroniser for the asynchronous raw input,
//   - a counter-based debouncer that only follows a changed level after it
//     has been stable for DEBOUNCE_CYCLES consecutive cycles,
//   - a registered rising-edge one-shot on the debounced level,
//   - (directional channels only) an auto-repeat FSM that re-issues the
//     pulse REPEAT_DELAY cycles after the press and every REPEAT_RATE cycles
//     after that while the button stays down.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed before the debounced level moves (>=1)
//   REPEAT_DELAY     press-to-first-repeat distance in cycles; 0 = no repeat
//   REPEAT_RATE      distance between subsequent repeats in cycles (>=1)
//
// Ports:
//   sysclk        in   system clock, everything on the rising edge
//   reset         in   synchronous active-high reset
//   east_raw      in   raw East button (async, active high)
//   west_raw      in   raw West button (async, active high)
//   north_raw     in   raw North button (async, active high)
//   south_raw     in   raw South button (async, active high)
//   scramble_raw  in   raw Scramble button (async, active high)
//   East          out  one-cycle pulse on East press or repeat
//   West          out  one-cycle pulse on West press or repeat
//   North         out  one-cycle pulse on North press or repeat
//   South         out  one-cycle pulse on South press or repeat
//   Scramble      out  one-cycle pulse on Scramble press (never repeats)
//   held          out  debounced levels {scramble,south,north,west,east}
// ---------------------------------------------------------------------------
module f3_button_cond #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       east_raw,
  input  logic       west_raw,
  input  logic       north_raw,
  input  logic       south_raw,
  input  logic       scramble_raw,
  output logic       East,
  output logic       West,
  output logic       North,
  output logic       South,
  output logic       Scramble,
  output logic [4:0] held
);

  // Debounce counter only ever needs to hold values up to DEBOUNCE_CYCLES-1;
  // the terminal compare fires one step before it would reach DEBOUNCE_CYCLES.
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  // Repeat counter is shared between the DELAY and REPEAT phases, so it is
  // sized for the larger of the two distances.
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W  = $clog2(REP_MAX + 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repState_e;

  // Channel order matches the held bus: bit 0 East ... bit 4 Scramble.
  logic [4:0] rawVec;
  logic [4:0] pulseVec;

  assign rawVec   = {scramble_raw, south_raw, north_raw, west_raw, east_raw};
  assign East     = pulseVec[0];
  assign West     = pulseVec[1];
  assign North    = pulseVec[2];
  assign South    = pulseVec[3];
  assign Scramble = pulseVec[4];

  for (genvar ch = 0; ch < 5; ch++) begin : g_chan
    logic             s1_q;
    logic             s2_q;
    logic             deb_q;
    logic             deb_d;
    logic             debDly_q;
    logic             rise;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    // Debounce next-state: any cycle where the synchronised level agrees with
    // the debounced level restarts the count, so only an uninterrupted run of
    // DEBOUNCE_CYCLES disagreeing cycles lets the debounced level follow.
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (s2_q != deb_q) begin
        if (cnt_q == DEB_LAST) begin
          deb_d = s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Synchroniser, debouncer state and a one-cycle-delayed copy of the
    // debounced level used to spot its rising edge.
    always_ff @(posedge sysclk) begin
      if (reset) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        deb_q    <= 1'b0;
        debDly_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        s1_q     <= rawVec[ch];
        s2_q     <= s1_q;
        deb_q    <= deb_d;
        debDly_q <= deb_q;
        cnt_q    <= cnt_d;
      end
    end

    // High for the single cycle after the debounced level went 0->1; the
    // press pulse is this term registered, so releases never pulse.
    assign rise     = deb_q & ~debDly_q;
    assign held[ch] = deb_q;

    if (ch < 4 && REPEAT_DELAY > 0) begin : g_rep
      repState_e         state_q;
      logic [RCNT_W-1:0] rcnt_q;
      logic              pulse_q;

      // Auto-repeat FSM. It arms on the same edge that registers the press
      // pulse, so the first repeat lands REPEAT_DELAY cycles after the press
      // pulse. A release is seen through deb_d, which drops the FSM back to
      // IDLE on the very edge the debounced level falls, suppressing any
      // repeat that would have coincided with it.
      always_ff @(posedge sysclk) begin
        if (reset) begin
          state_q <= IDLE;
          rcnt_q  <= '0;
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= rise;
          case (state_q)
            IDLE: begin
              if (rise) begin
                state_q <= DELAY;
                rcnt_q  <= '0;
              end
            end
            DELAY: begin
              if (!deb_d) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
              end else if (rcnt_q == DELAY_LAST) begin
                pulse_q <= 1'b1;
                state_q <= REPEAT;
                rcnt_q  <= '0;
              end else begin
                rcnt_q <= rcnt_q + 1'b1;
              end
            end
            REPEAT: begin
              if (!deb_d) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
              end else if (rcnt_q == RATE_LAST) begin
                pulse_q <= 1'b1;
                rcnt_q  <= '0;
              end else begin
                rcnt_q <= rcnt_q + 1'b1;
              end
            end
            default: begin
              state_q <= IDLE;
              rcnt_q  <= '0;
            end
          endcase
        end
      end

      assign pulseVec[ch] = pulse_q;
    end else begin : g_oneshot
      logic pulse_q;

      // Press-only channel: the registered rising edge is the whole output.
      always_ff @(posedge sysclk) begin
        if (reset) begin
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= rise;
        end
      end

      assign pulseVec[ch] = pulse_q;
    end
  end

endmodule

// File: tb/tb_f3_button_cond.sv
// ---------------------------------------------------------------------------
// tb_f3_button_cond
//
// Drives two copies of f3_button_cond from the same raw buttons: one with
// auto-repeat (DEBOUNCE 4, DELAY 20, RATE 8) and one without (DELAY 0).
// A timeline-based reference model predicts the pulse and held outputs of
// both copies every cycle; directed scenarios additionally check pulse
// counts against hand-derived constants, then a randomized phase mixes
// glitches, long holds and occasional resets.
// ---------------------------------------------------------------------------
module tb_f3_button_cond;

  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RR   = 8;
  localparam int MAXE = 8192;

  logic sysclk;
  logic reset;
  logic east_raw, west_raw, north_raw, south_raw, scramble_raw;

  logic eastRep, westRep, northRep, southRep, scrambleRep;
  logic eastNo, westNo, northNo, southNo, scrambleNo;
  logic [4:0] heldRep, heldNo;

  int checkCount = 0;
  int errorCount = 0;
  bit checkEn = 0;

  // Reference model state: a record of every raw sample by edge number, plus
  // the debounced level and the edge numbers of its last rise/fall and of the
  // last press pulse per channel.
  bit         rawAt [5][MAXE];
  int         edgeN = 0;
  int         rstEdge = 0;
  bit         debM [5];
  int         lastRise [5];
  int         lastFall [5];
  int         pressE [5];
  logic [4:0] expRep = '0;
  logic [4:0] expNoRep = '0;
  logic [4:0] expHeld = '0;
  logic [4:0] rawNow;
  bit         flip, press, rep, smp;

  int obsRep [5];
  int obsNo [5];
  int baseRep [5];
  int baseNo [5];

  int         durLeft [5];
  logic [4:0] randBits;

  f3_button_cond #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dutRep (
    .sysclk(sysclk),
    .reset(reset),
    .east_raw(east_raw),
    .west_raw(west_raw),
    .north_raw(north_raw),
    .south_raw(south_raw),
    .scramble_raw(scramble_raw),
    .East(eastRep),
    .West(westRep),
    .North(northRep),
    .South(southRep),
    .Scramble(scrambleRep),
    .held(heldRep)
  );

  f3_button_cond #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(0),
    .REPEAT_RATE(RR)
  ) dutNoRep (
    .sysclk(sysclk),
    .reset(reset),
    .east_raw(east_raw),
    .west_raw(west_raw),
    .north_raw(north_raw),
    .south_raw(south_raw),
    .scramble_raw(scramble_raw),
    .East(eastNo),
    .West(westNo),
    .North(northNo),
    .South(southNo),
    .Scramble(scrambleNo),
    .held(heldNo)
  );

  // 10-unit clock period.
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Set the raw buttons and reset, then let one clock cycle go by.
  task automatic applyStimulus(input logic [4:0] bits, input logic rst);
    east_raw     = bits[0];
    west_raw     = bits[1];
    north_raw    = bits[2];
    south_raw    = bits[3];
    scramble_raw = bits[4];
    reset        = rst;
    @(negedge sysclk);
  endtask

  task automatic holdFor(input logic [4:0] bits, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(bits, 1'b0);
  endtask

  task automatic takeSnapshot();
    for (int c = 0; c < 5; c++) begin
      baseRep[c] = obsRep[c];
      baseNo[c]  = obsNo[c];
    end
  endtask

  // Reference model, evaluated on every clock edge from the button timeline:
  //   - the synchronised level seen at edge k is the raw sample of edge k-2
  //     (zero if that sample predates the last reset);
  //   - the debounced level flips at edge n when the synchronised levels of
  //     the last D edges (all after the last reset) disagree with it;
  //   - a press pulse follows one edge after a debounced rise;
  //   - a directional repeat falls on press + RD + k*RR while the debounced
  //     level has not fallen since the press.
  always @(posedge sysclk) begin
    rawNow = {scramble_raw, south_raw, north_raw, west_raw, east_raw};
    edgeN++;
    if (edgeN >= MAXE) begin
      $display("[TB] FAIL model_range: edge %0d, limit %0d", edgeN, MAXE);
      $fatal(1, "[TB] model timeline exhausted");
    end
    for (int c = 0; c < 5; c++) rawAt[c][edgeN] = rawNow[c];
    if (reset) begin
      rstEdge = edgeN;
      for (int c = 0; c < 5; c++) begin
        debM[c]     = 1'b0;
        lastRise[c] = -1000;
        lastFall[c] = -1000;
        pressE[c]   = -1000;
      end
      expRep   = '0;
      expNoRep = '0;
      expHeld  = '0;
    end else begin
      for (int c = 0; c < 5; c++) begin
        flip = (edgeN - D + 1 > rstEdge);
        for (int k = edgeN - D + 1; k <= edgeN; k++) begin
          smp = (k - 2 > rstEdge) ? rawAt[c][k-2] : 1'b0;
          if (smp == debM[c]) flip = 1'b0;
        end
        if (flip) begin
          debM[c] = ~debM[c];
          if (debM[c]) lastRise[c] = edgeN;
          else         lastFall[c] = edgeN;
        end
        press = (lastRise[c] == edgeN - 1);
        if (press) pressE[c] = edgeN;
        rep = (c < 4) && debM[c] && (lastFall[c] < pressE[c]) &&
              (edgeN >= pressE[c] + RD) && (((edgeN - pressE[c] - RD) % RR) == 0);
        expRep[c]   = press | rep;
        expNoRep[c] = press;
        expHeld[c]  = debM[c];
      end
    end
  end

  // Compare both copies against the model shortly after each edge, and
  // tally observed pulses for the directed count checks.
  always @(posedge sysclk) begin
    #1;
    if (checkEn) begin
      checkOutput("pulse_rep", {27'd0, scrambleRep, southRep, northRep, westRep, eastRep}, {27'd0, expRep});
      checkOutput("pulse_norep", {27'd0, scrambleNo, southNo, northNo, westNo, eastNo}, {27'd0, expNoRep});
      checkOutput("held_rep", {27'd0, heldRep}, {27'd0, expHeld});
      checkOutput("held_norep", {27'd0, heldNo}, {27'd0, expHeld});
      obsRep[0] += int'(eastRep);
      obsRep[1] += int'(westRep);
      obsRep[2] += int'(northRep);
      obsRep[3] += int'(southRep);
      obsRep[4] += int'(scrambleRep);
      obsNo[0]  += int'(eastNo);
      obsNo[1]  += int'(westNo);
      obsNo[2]  += int'(northNo);
      obsNo[3]  += int'(southNo);
      obsNo[4]  += int'(scrambleNo);
    end
  end

  initial begin
    for (int c = 0; c < 5; c++) begin
      obsRep[c] = 0;
      obsNo[c]  = 0;
    end

    // Reset, then start checking while reset is still applied.
    applyStimulus(5'b00000, 1'b1);
    applyStimulus(5'b00000, 1'b1);
    checkEn = 1'b1;
    applyStimulus(5'b00000, 1'b1);
    holdFor(5'b00000, 5);

    // East held 40 cycles: one press, repeats at +20, +28, +36 on the
    // repeating copy; nothing else moves.
    takeSnapshot();
    holdFor(5'b00001, 40);
    holdFor(5'b00000, 20);
    checkOutput("east_norep_count", obsNo[0] - baseNo[0], 1);
    checkOutput("east_rep_count", obsRep[0] - baseRep[0], 4);
    for (int c = 1; c < 5; c++) checkOutput("east_others_quiet", obsNo[c] - baseNo[c], 0);

    // North glitches of 3 cycles never get through.
    takeSnapshot();
    for (int i = 0; i < 5; i++) begin
      holdFor(5'b00100, 3);
      holdFor(5'b00000, 3);
    end
    holdFor(5'b00000, 10);
    checkOutput("north_glitch_count", obsRep[2] - baseRep[2], 0);

    // South held 60 cycles: press plus repeats at +20, +28, +36, +44, +52.
    takeSnapshot();
    holdFor(5'b01000, 60);
    holdFor(5'b00000, 30);
    checkOutput("south_rep_count", obsRep[3] - baseRep[3], 6);
    checkOutput("south_norep_count", obsNo[3] - baseNo[3], 1);

    // Scramble held 60 cycles: a single press, no repeats.
    takeSnapshot();
    holdFor(5'b10000, 60);
    holdFor(5'b00000, 30);
    checkOutput("scramble_count", obsRep[4] - baseRep[4], 1);

    // East and West together; same-cycle alignment is covered per cycle.
    takeSnapshot();
    holdFor(5'b00011, 10);
    holdFor(5'b00000, 20);
    checkOutput("ew_east_count", obsRep[0] - baseRep[0], 1);
    checkOutput("ew_west_count", obsRep[1] - baseRep[1], 1);

    // West held; one-cycle reset 10 cycles into DELAY. Afterwards West
    // re-presses 7 edges after the reset edge, repeats at +20, +28, +36, +44,
    // and release after 50 cycles ends the sequence.
    holdFor(5'b00010, 17);
    applyStimulus(5'b00010, 1'b1);
    takeSnapshot();
    holdFor(5'b00010, 50);
    holdFor(5'b00000, 30);
    checkOutput("reset_west_rep_count", obsRep[1] - baseRep[1], 5);
    checkOutput("reset_west_norep_count", obsNo[1] - baseNo[1], 1);

    // Randomized phase: per-channel runs of random length (short glitches
    // and long holds) with rare resets.
    randBits = '0;
    for (int c = 0; c < 5; c++) durLeft[c] = int'($urandom_range(1, 20));
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < 5; c++) begin
        if (durLeft[c] == 0) begin
          randBits[c] = ~randBits[c];
          if ($urandom_range(0, 1) == 0) durLeft[c] = int'($urandom_range(1, 5));
          else                           durLeft[c] = int'($urandom_range(6, 45));
        end else begin
          durLeft[c]--;
        end
      end
      applyStimulus(randBits, ($urandom_range(0, 399) == 0));
    end
    holdFor(5'b00000, 30);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
